// File: rtl/whitening_apply_pkg.sv
// Shared definitions for the whitening stage.
//   state_t    : FSM state encoding (IDLE, MAC, OUT)
//   acc_width  : full-precision accumulator width for a given geometry
//   cnt_width  : width of the row/column index counters
package whitening_apply_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Sum of N_CH products of X_W x V_W signed operands never overflows this width.
    function automatic int acc_width(input int x_w, input int v_w, input int n_ch);
        return x_w + v_w + $clog2(n_ch);
    endfunction

    function automatic int cnt_width(input int n_ch);
        return (n_ch < 2) ? 1 : $clog2(n_ch);
    endfunction

endpackage

// File: rtl/whitening_apply_mac.sv
// Time-shared multiply-accumulate for the whitening stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the accumulator (new sample accepted)
//   en         : add coef*sample this cycle
//   last       : final product of a row; accumulator restarts at zero next cycle
//   coef       : V coefficient, signed, V_FRAC fraction bits
//   sample     : X channel value, signed integer
//   res, sat   : rounded/clamped row result including this cycle's product, clamp flag
module whitening_apply_mac
    import whitening_apply_pkg::*;
#(
    parameter int X_W    = 16,
    parameter int V_W    = 26,
    parameter int V_FRAC = 16,
    parameter int Z_W    = 26,
    parameter int ACC_W  = 44
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  last,
    input  logic signed [V_W-1:0] coef,
    input  logic signed [X_W-1:0] sample,
    output logic signed [Z_W-1:0] res,
    output logic                  sat
);

    localparam logic signed [ACC_W:0] RND_C = {{ACC_W{1'b0}}, 1'b1} << (V_FRAC - 1);
    localparam logic signed [ACC_W:0] Z_MAX = {{(ACC_W + 2 - Z_W){1'b0}}, {(Z_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] Z_MIN = {{(ACC_W + 2 - Z_W){1'b1}}, {(Z_W - 1){1'b0}}};

    logic signed [V_W+X_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W:0]     rnd;
    logic signed [ACC_W:0]     shifted;

    assign prod     = coef * sample;
    assign acc_next = acc + ACC_W'(prod);

    // One extra bit so adding the half-LSB can never wrap; arithmetic shift
    // then gives round-half-toward-+inf.
    assign rnd     = {acc_next[ACC_W-1], acc_next} + RND_C;
    assign shifted = rnd >>> V_FRAC;

    always_comb begin
        res = shifted[Z_W-1:0];
        sat = 1'b0;
        if (shifted > Z_MAX) begin
            res = Z_MAX[Z_W-1:0];
            sat = 1'b1;
        end else if (shifted < Z_MIN) begin
            res = Z_MIN[Z_W-1:0];
            sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= last ? '0 : acc_next;
        end
    end

endmodule

// File: rtl/whitening_apply.sv
// Whitening stage: Z = V * X for N_CH-channel samples using one shared MAC
// (one product per cycle), with a loadable V matrix and per-channel clamp flags.
//   CLK_whitening, RSTn_whitening : clock, asynchronous active-low reset
//   X_valid / X_ready / X         : input sample handshake, channel i at X[i*X_W +: X_W]
//   Z_valid / Z_ready / Z / Z_sat : output vector handshake, channel i at Z[i*Z_W +: Z_W]
//   V_wr_en/row/col/data          : coefficient write port, honoured only in IDLE
//   V_wr_err                      : one-cycle pulse when a write is dropped
//   Whitening_busy                : high in MAC and OUT
//
// state | meaning
// IDLE  | waiting for a sample, V writable
// MAC   | row-major V[r][c]*X[c] products, Z[r] written at each row end
// OUT   | Z held until Z_ready; a sample offered then starts MAC directly
module whitening_apply
    import whitening_apply_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int X_W    = 16,
    parameter int V_W    = 26,
    parameter int V_FRAC = 16,
    parameter int Z_W    = 26
) (
    input  logic                CLK_whitening,
    input  logic                RSTn_whitening,
    input  logic                X_valid,
    output logic                X_ready,
    input  logic [N_CH*X_W-1:0] X,
    output logic                Z_valid,
    input  logic                Z_ready,
    output logic [N_CH*Z_W-1:0] Z,
    output logic [N_CH-1:0]     Z_sat,
    input  logic                V_wr_en,
    input  logic [3:0]          V_wr_row,
    input  logic [3:0]          V_wr_col,
    input  logic [V_W-1:0]      V_wr_data,
    output logic                V_wr_err,
    output logic                Whitening_busy
);

    localparam int ACC_W = acc_width(X_W, V_W, N_CH);
    localparam int CNT_W = cnt_width(N_CH);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(N_CH - 1);
    localparam logic [4:0]       N_CH_5 = 5'(N_CH);
    localparam logic signed [V_W-1:0] V_ONE = {{(V_W - 1){1'b0}}, 1'b1} << V_FRAC;

    state_t                  state;
    logic [CNT_W-1:0]        row;
    logic [CNT_W-1:0]        col;
    logic signed [X_W-1:0]   x_in   [N_CH];
    logic signed [X_W-1:0]   x_reg  [N_CH];
    logic signed [V_W-1:0]   v_mem  [N_CH][N_CH];
    logic signed [Z_W-1:0]   z_reg  [N_CH];
    logic [N_CH-1:0]         z_sat_reg;
    logic                    z_valid_reg;
    logic                    busy_reg;
    logic                    wr_err_reg;

    logic                    x_accept;
    logic                    wr_ok;
    logic                    mac_en;
    logic                    row_end;
    logic signed [V_W-1:0]   mac_coef;
    logic signed [X_W-1:0]   mac_sample;
    logic signed [Z_W-1:0]   mac_res;
    logic                    mac_sat;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign x_in[g]           = X[g*X_W +: X_W];
        assign Z[g*Z_W +: Z_W]   = z_reg[g];
    end

    // Combinational from Z_ready so a waiting sample can be taken in the same
    // cycle the result leaves, giving back-to-back vectors with no IDLE gap.
    assign X_ready        = (state == ST_IDLE) | ((state == ST_OUT) & Z_ready);
    assign x_accept       = X_valid & X_ready;
    assign Z_valid        = z_valid_reg;
    assign Z_sat          = z_sat_reg;
    assign V_wr_err       = wr_err_reg;
    assign Whitening_busy = busy_reg;

    assign mac_en     = (state == ST_MAC);
    assign row_end    = (col == LAST);
    assign mac_coef   = v_mem[row][col];
    assign mac_sample = x_reg[col];

    whitening_apply_mac #(
        .X_W    (X_W),
        .V_W    (V_W),
        .V_FRAC (V_FRAC),
        .Z_W    (Z_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (CLK_whitening),
        .rst_n  (RSTn_whitening),
        .clr    (x_accept),
        .en     (mac_en),
        .last   (row_end),
        .coef   (mac_coef),
        .sample (mac_sample),
        .res    (mac_res),
        .sat    (mac_sat)
    );

    always_ff @(posedge CLK_whitening or negedge RSTn_whitening) begin
        if (!RSTn_whitening) begin
            state       <= ST_IDLE;
            row         <= '0;
            col         <= '0;
            z_sat_reg   <= '0;
            z_valid_reg <= 1'b0;
            busy_reg    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                x_reg[i] <= '0;
                z_reg[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (X_valid) begin
                        for (int i = 0; i < N_CH; i++) x_reg[i] <= x_in[i];
                        row      <= '0;
                        col      <= '0;
                        busy_reg <= 1'b1;
                        state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (row_end) begin
                        col            <= '0;
                        z_reg[row]     <= mac_res;
                        z_sat_reg[row] <= mac_sat;
                        if (row == LAST) begin
                            row         <= '0;
                            z_valid_reg <= 1'b1;
                            state       <= ST_OUT;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (Z_ready) begin
                        z_valid_reg <= 1'b0;
                        if (X_valid) begin
                            for (int i = 0; i < N_CH; i++) x_reg[i] <= x_in[i];
                            row   <= '0;
                            col   <= '0;
                            state <= ST_MAC;
                        end else begin
                            busy_reg <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_reg    <= 1'b0;
                    z_valid_reg <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // A write in the same IDLE cycle as a sample lands before the first MAC
    // read, so that sample already sees the new coefficient.
    assign wr_ok = V_wr_en && (state == ST_IDLE)
                   && ({1'b0, V_wr_row} < N_CH_5) && ({1'b0, V_wr_col} < N_CH_5);

    always_ff @(posedge CLK_whitening or negedge RSTn_whitening) begin
        if (!RSTn_whitening) begin
            wr_err_reg <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                for (int j = 0; j < N_CH; j++) begin
                    v_mem[i][j] <= (i == j) ? V_ONE : '0;
                end
            end
        end else begin
            wr_err_reg <= V_wr_en && !wr_ok;
            if (wr_ok) begin
                v_mem[V_wr_row[CNT_W-1:0]][V_wr_col[CNT_W-1:0]] <= V_wr_data;
            end
        end
    end

endmodule
